// File: rtl/i2s_tx_stereo_if.sv
// Sample-pair stream between an audio source and the stereo I2S transmitter.
//   s_valid : source offers {s_left, s_right}
//   s_ready : sink can take a pair this cycle
//   s_left  : left sample, two's complement
//   s_right : right sample, two's complement
// A pair moves on any rising clk edge where s_valid and s_ready are both high.
interface i2s_tx_stereo_if #(
  parameter int DATA_W = 16
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_left;
  logic [DATA_W-1:0] s_right;

  modport master (output s_valid, s_left, s_right, input s_ready);
  modport slave  (input s_valid, s_left, s_right, output s_ready);
endinterface

// File: rtl/i2s_tx_stereo.sv
// Stereo I2S transmitter. BCK, LRCK and DIN are ordinary registers in the clk
// domain. A fractional phase accumulator produces the BCK half periods.
// Ports:
//   clk, sys_rst_n : system clock; asynchronous active-low reset
//   en             : run request; stopping always ends on a frame boundary
//   fmt_lj         : 0 = I2S (MSB one BCK late), 1 = left-justified
//   s              : sample-pair stream into a one-entry holding register
//   i2s_bck/lrck/din : DAC pins (lrck 0 = left slot)
//   busy           : transmitter not idle
//   frame_start    : one-clk pulse on every frame load
//   underrun       : one-clk pulse when a frame loads with no pair waiting
module i2s_tx_stereo #(
  parameter int DATA_W = 16,
  parameter int SLOT_W = 32,
  parameter int CLK_HZ = 6000000,
  parameter int BCK_HZ = 2822400
) (
  input  logic           clk,
  input  logic           sys_rst_n,
  input  logic           en,
  input  logic           fmt_lj,
  i2s_tx_stereo_if.slave s,
  output logic           i2s_bck,
  output logic           i2s_lrck,
  output logic           i2s_din,
  output logic           busy,
  output logic           frame_start,
  output logic           underrun
);
  localparam int                 IDX_W    = $clog2(2 * SLOT_W);
  localparam logic [IDX_W-1:0]   SLOT_IDX = IDX_W'(SLOT_W);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(2 * SLOT_W - 1);
  localparam logic [31:0]        STEP     = 32'(2 * BCK_HZ);
  localparam logic [31:0]        LIMIT    = 32'(CLK_HZ);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state, state_n;
  logic [31:0]       acc, acc_sum;
  logic [IDX_W-1:0]  bit_idx, idx_next;
  logic [DATA_W-1:0] hold_l, hold_r;
  logic [DATA_W-1:0] word_l, word_r;   // words of the frame being sent
  logic [DATA_W-1:0] ld_l, ld_r;       // words in force after this cycle
  logic              hold_full, fmt_q, fmt_sel;
  logic              half_tick, rise, fall, wrap, load, stop, xfer;

  // Serial bit for bit position idx of a frame carrying words wl/wr.
  // Shifting past the word yields the zero padding at the end of the slot.
  function automatic logic din_of(input logic [IDX_W-1:0]  idx,
                                  input logic              lj,
                                  input logic [DATA_W-1:0] wl,
                                  input logic [DATA_W-1:0] wr);
    logic [IDX_W-1:0]  k;
    logic [DATA_W-1:0] w;
    logic [DATA_W-1:0] sh;
    if (idx >= SLOT_IDX) begin
      k = idx - SLOT_IDX;
      w = wr;
    end else begin
      k = idx;
      w = wl;
    end
    if (lj)            sh = w << k;
    else if (k == '0)  sh = '0;
    else               sh = w << (k - IDX_W'(1));
    return sh[DATA_W-1];
  endfunction

  assign s.s_ready = !hold_full;
  assign xfer      = s.s_valid && !hold_full;
  assign busy      = (state != IDLE);

  // A load with nothing waiting sends an all-zero frame.
  assign ld_l    = load ? (hold_full ? hold_l : '0) : word_l;
  assign ld_r    = load ? (hold_full ? hold_r : '0) : word_r;
  assign fmt_sel = load ? fmt_lj : fmt_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves one unassigned, which would infer a latch.
    state_n   = state;
    load      = 1'b0;
    stop      = 1'b0;
    acc_sum   = acc + STEP;
    half_tick = (state != IDLE) && (acc_sum >= LIMIT);
    rise      = half_tick && !i2s_bck;
    fall      = half_tick && i2s_bck;
    wrap      = fall && (bit_idx == LAST_IDX);
    idx_next  = (bit_idx == LAST_IDX) ? '0 : bit_idx + 1'b1;
    unique case (state)
      IDLE: begin
        if (en) begin
          load    = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (wrap) load = 1'b1;
        if (!en)  state_n = DRAIN;
      end
      DRAIN: begin
        // Stop on the falling edge that would begin the next frame.
        if (wrap) begin
          stop    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: state is assigned with <= so every register samples the values
  // from before this edge, independent of block ordering.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_n;
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      // NOTE: the holding data is cleared too, so a pair offered before a
      // reset can never reappear in a later frame.
      hold_l      <= '0;
      hold_r      <= '0;
      hold_full   <= 1'b0;
      word_l      <= '0;
      word_r      <= '0;
      fmt_q       <= 1'b0;
      acc         <= '0;
      bit_idx     <= '0;
      i2s_bck     <= 1'b0;
      i2s_lrck    <= 1'b0;
      i2s_din     <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= load;
      underrun    <= load && !hold_full;

      // A pair accepted in a load cycle waits for the following frame.
      if (xfer) begin
        hold_l    <= s.s_left;
        hold_r    <= s.s_right;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end

      if (load) begin
        word_l <= ld_l;
        word_r <= ld_r;
        fmt_q  <= fmt_lj;
      end

      if (state == IDLE || stop) acc <= '0;
      else if (half_tick)        acc <= acc_sum - LIMIT;
      else                       acc <= acc_sum;

      if (stop) begin
        i2s_bck  <= 1'b0;
        i2s_lrck <= 1'b0;
        i2s_din  <= 1'b0;
        bit_idx  <= '0;
      end else if (state == IDLE) begin
        // On entry DIN shows bit position 0 before the first rising edge.
        i2s_bck  <= 1'b0;
        i2s_lrck <= 1'b0;
        i2s_din  <= load ? din_of('0, fmt_sel, ld_l, ld_r) : 1'b0;
        bit_idx  <= '0;
      end else if (rise) begin
        i2s_bck <= 1'b1;
      end else if (fall) begin
        i2s_bck  <= 1'b0;
        bit_idx  <= idx_next;
        i2s_lrck <= (idx_next >= SLOT_IDX);
        i2s_din  <= din_of(idx_next, fmt_sel, ld_l, ld_r);
      end
    end
  end
endmodule
